// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply (radix-2 Booth) and divide (restoring) unit with HI/LO results.
// One iteration per cycle; FIX applies the divide signs before the result lands in HI/LO.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mult_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic [31:0] m_q, m_d;
  logic        q1_q, q1_d;
  logic        is_div_q, is_div_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

  logic [32:0] booth_add, booth_sub, booth_sum;
  logic [32:0] div_shift, div_trial;
  logic [31:0] acc_fix, mq_fix;

  // Booth accumulates in 33 bits so that +/- 0x80000000 cannot overflow before the shift.
  assign booth_add = {acc_q[31], acc_q} + {m_q[31], m_q};
  assign booth_sub = {acc_q[31], acc_q} - {m_q[31], m_q};
  assign div_shift = {acc_q, mq_q[31]};
  assign div_trial = div_shift - {1'b0, m_q};
  assign acc_fix   = (is_div_q && rem_neg_q) ? -acc_q : acc_q;
  assign mq_fix    = (is_div_q && quo_neg_q) ? -mq_q : mq_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    m_d       = m_q;
    q1_d      = q1_q;
    is_div_d  = is_div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    booth_sum = {acc_q[31], acc_q};

    case (state_q)
      IDLE: begin
        if (mult_div == 2'b01 || mult_div == 2'b10) begin
          is_div_d  = mult_div[1];
          cnt_d     = 6'd0;
          q1_d      = 1'b0;
          acc_d     = 32'd0;
          busy_d    = 1'b1;
          quo_neg_d = a[31] ^ b[31];
          rem_neg_d = a[31];
          if (mult_div[1]) begin
            mq_d = a[31] ? -a : a;
            m_d  = b[31] ? -b : b;
          end else begin
            mq_d = b;
            m_d  = a;
          end
          if (mult_div[1] && b == 32'd0) begin
            state_d = DONE;
            div0_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div_q) begin
          if (!div_trial[32]) begin
            acc_d = div_trial[31:0];
            mq_d  = {mq_q[30:0], 1'b1};
          end else begin
            acc_d = div_shift[31:0];
            mq_d  = {mq_q[30:0], 1'b0};
          end
        end else begin
          case ({mq_q[0], q1_q})
            2'b01:   booth_sum = booth_add;
            2'b10:   booth_sum = booth_sub;
            default: booth_sum = {acc_q[31], acc_q};
          endcase
          acc_d = booth_sum[32:1];
          mq_d  = {booth_sum[0], mq_q[31:1]};
          q1_d  = mq_q[0];
        end
        if (cnt_q == 6'd31) state_d = FIX;
      end

      FIX: begin
        acc_d   = acc_fix;
        mq_d    = mq_fix;
        hi_d    = acc_fix;
        lo_d    = mq_fix;
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 32'd0;
      mq_q      <= 32'd0;
      m_q       <= 32'd0;
      q1_q      <= 1'b0;
      is_div_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      is_div_q  <= is_div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a plain-arithmetic HI/LO model.
// Latency is counted in falling edges after the start edge; done is due at the 34th.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mult_div;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div0;

  int total = 0;
  int bad   = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .mult_div(mult_div), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic; longint division avoids the 0x80000000 / -1 trap.
  task automatic modelOp(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output bit isDiv0);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    isDiv0 = 1'b0;
    if (op == 2'b01) begin
      p = sx * sy;
      expHi = p[63:32];
      expLo = p[31:0];
    end else if (y == 32'd0) begin
      isDiv0 = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      expHi = r[31:0];
      expLo = q[31:0];
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the unit idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                               input int injectAt);
    bit isDiv0;
    int doneAt;
    bit busyGap;
    bit sawDiv0;
    logic [31:0] oldHi, oldLo;
    oldHi = expHi;
    oldLo = expLo;
    modelOp(op, x, y, isDiv0);
    mult_div = op;
    a = x;
    b = y;
    @(negedge clock);
    mult_div = 2'b00;
    a = $urandom;
    b = $urandom;
    if (isDiv0) begin
      checkOutput("div0_pulse", div0, 1);
      checkOutput("div0_no_done", done, 0);
      checkOutput("div0_busy", busy, 1);
      checkOutput("div0_hi_kept", hi, oldHi);
      checkOutput("div0_lo_kept", lo, oldLo);
      @(negedge clock);
      checkOutput("div0_width", div0, 0);
      checkOutput("div0_busy_end", busy, 0);
      checkOutput("div0_no_late_done", done, 0);
      return;
    end
    doneAt  = 0;
    busyGap = 1'b0;
    sawDiv0 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (div0) sawDiv0 = 1'b1;
      if (done) begin
        doneAt = n;
        break;
      end
      if (!busy) busyGap = 1'b1;
      if (hi !== oldHi || lo !== oldLo) busyGap = 1'b1;
      mult_div = (n == injectAt) ? 2'b10 : 2'b00;
      @(negedge clock);
    end
    mult_div = 2'b00;
    checkOutput("latency", doneAt, 34);
    checkOutput("busy_hold", busyGap, 0);
    checkOutput("no_div0", sawDiv0, 0);
    checkOutput("busy_at_done", busy, 1);
    checkOutput("hi", hi, expHi);
    checkOutput("lo", lo, expLo);
    @(negedge clock);
    checkOutput("done_width", done, 0);
    checkOutput("busy_end", busy, 0);
  endtask

  initial begin
    bit isDiv0;
    int sawDone;
    logic [1:0]  op;
    logic [31:0] x, y;

    reset = 1'b1;
    mult_div = 2'b00;
    a = 32'd0;
    b = 32'd0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_div0", div0, 0);
    reset = 1'b0;

    // First command goes in on the very first edge with reset low.
    applyStimulus(2'b01, 32'd7, -32'sd3, 0);
    checkOutput("mul_7x-3_hi", hi, 32'hFFFFFFFF);
    checkOutput("mul_7x-3_lo", lo, 32'hFFFFFFEB);
    applyStimulus(2'b01, 32'h80000000, 32'h80000000, 0);
    checkOutput("mul_min_hi", hi, 32'h40000000);
    applyStimulus(2'b10, -32'sd7, 32'd2, 0);
    checkOutput("div_-7/2_lo", lo, 32'hFFFFFFFD);
    applyStimulus(2'b10, 32'd7, -32'sd2, 0);
    checkOutput("div_7/-2_hi", hi, 32'h00000001);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("div_ovf_lo", lo, 32'h80000000);
    checkOutput("div_ovf_hi", hi, 32'h0);
    applyStimulus(2'b10, 32'd5, 32'd2, 0);
    applyStimulus(2'b10, 32'd5, 32'd0, 0);
    checkOutput("div0_kept_hi", hi, 32'd1);
    checkOutput("div0_kept_lo", lo, 32'd2);

    // A DIV issued mid-CALC must be dropped without disturbing the running MULT.
    applyStimulus(2'b01, 32'h12345678, 32'hFEDCBA98, 10);

    // Opcode 11 is a no-op in IDLE.
    mult_div = 2'b11;
    a = 32'd9;
    b = 32'd0;
    repeat (3) @(negedge clock);
    mult_div = 2'b00;
    checkOutput("nop11_busy", busy, 0);
    checkOutput("nop11_hi", hi, expHi);
    checkOutput("nop11_lo", lo, expLo);

    // Asynchronous reset in the middle of CALC aborts the operation.
    modelOp(2'b01, 32'd1234, 32'd5678, isDiv0);
    mult_div = 2'b01;
    a = 32'd1234;
    b = 32'd5678;
    @(negedge clock);
    mult_div = 2'b00;
    repeat (15) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_hi", hi, 0);
    checkOutput("arst_lo", lo, 0);
    checkOutput("arst_done", done, 0);
    expHi = 32'd0;
    expLo = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    sawDone = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) sawDone++;
      @(negedge clock);
    end
    checkOutput("arst_no_done", sawDone, 0);
    applyStimulus(2'b10, 32'd100, 32'd7, 0);
    checkOutput("div_100/7_lo", lo, 32'd14);
    checkOutput("div_100/7_hi", hi, 32'd2);

    // Randomized mix with corner operands and occasional zero divisors.
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        3: y = $urandom_range(1, 16);
        4: x = $urandom_range(0, 255);
        default: ;
      endcase
      applyStimulus(op, x, y, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
